id_ex_stage: RTL and testbench

//  ID->EX pipeline register feeding the ALU's a/b/funct3/funct7/op/op_imm ports. Captures a

---
 rtl/id_ex_stage.sv | 177 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: captures a decoded instruction, resolves rs1/rs2 through
// ALU/MEM/WB forwarding, stalls on load-use and honours valid/ready on both sides.

module id_ex_fwd_mux #(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [4:0]      idx,
  input  logic [XLEN-1:0] rf_data,
  input  logic            s0_en,
  input  logic [4:0]      s0_rd,
  input  logic [XLEN-1:0] s0_data,
  input  logic            s1_en,
  input  logic [4:0]      s1_rd,
  input  logic [XLEN-1:0] s1_data,
  input  logic            s2_en,
  input  logic [4:0]      s2_rd,
  input  logic [XLEN-1:0] s2_data,
  output logic [XLEN-1:0] val
);
  always_comb begin
    val = rf_data;
    if (idx == 5'd0) begin
      val = '0;
    end else if (FWD_EN) begin
      if (s0_en && s0_rd == idx)      val = s0_data;
      else if (s1_en && s1_rd == idx) val = s1_data;
      else if (s2_en && s2_rd == idx) val = s2_data;
    end
  end
endmodule

module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_uses_rs1,
  input  logic            in_uses_rs2,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic            in_op,
  input  logic            in_op_imm,
  input  logic            in_is_load,
  input  logic            in_reg_write,
  input  logic [XLEN-1:0] alu_res,
  input  logic            mem_fwd_valid,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_valid,
  input  logic [4:0]      wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            op,
  output logic            op_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_is_load,
  output logic            out_reg_write
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] store_data;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            op;
    logic            op_imm;
    logic [4:0]      rd;
    logic            is_load;
    logic            reg_write;
  } ex_pkt_t;

  ex_pkt_t pkt_q, pkt_d;
  logic    out_valid_q, out_valid_d;
  logic    hazard, capture, alu_fwd_en;

  logic [1:0][4:0]      src_idx;
  logic [1:0][XLEN-1:0] src_rf;
  logic [1:0][XLEN-1:0] src_val;

  assign src_idx = {in_rs2, in_rs1};
  assign src_rf  = {in_rs2_data, in_rs1_data};

  // ALU result only forwards when the producer actually leaves this cycle
  assign alu_fwd_en = out_valid_q & out_ready & pkt_q.reg_write & ~pkt_q.is_load;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_src
      id_ex_fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd (
        .idx     (src_idx[g]),
        .rf_data (src_rf[g]),
        .s0_en   (alu_fwd_en),
        .s0_rd   (pkt_q.rd),
        .s0_data (alu_res),
        .s1_en   (mem_fwd_valid),
        .s1_rd   (mem_fwd_rd),
        .s1_data (mem_fwd_data),
        .s2_en   (wb_fwd_valid),
        .s2_rd   (wb_fwd_rd),
        .s2_data (wb_fwd_data),
        .val     (src_val[g])
      );
    end
  endgenerate

  assign hazard = out_valid_q & pkt_q.is_load & (pkt_q.rd != 5'd0) &
                  ((in_uses_rs1 & (in_rs1 == pkt_q.rd)) | (in_uses_rs2 & (in_rs2 == pkt_q.rd)));
  assign in_ready = (~out_valid_q | out_ready) & ~hazard;
  assign capture  = in_valid & in_ready & ~flush;

  always_comb begin
    pkt_d       = pkt_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d       = 1'b1;
      pkt_d.pc          = in_pc;
      pkt_d.a           = src_val[0];
      pkt_d.b           = in_op_imm ? in_imm : src_val[1];
      pkt_d.store_data  = src_val[1];
      pkt_d.funct3      = in_funct3;
      // Only SRAI-style shifts carry meaningful funct7 among immediate ops
      pkt_d.funct7      = (in_op_imm && in_funct3 != 3'b101) ? 7'b0 : in_funct7;
      pkt_d.op          = in_op;
      pkt_d.op_imm      = in_op_imm;
      pkt_d.rd          = in_rd;
      pkt_d.is_load     = in_is_load;
      pkt_d.reg_write   = in_reg_write;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pkt_q       <= pkt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign a              = pkt_q.a;
  assign b              = pkt_q.b;
  assign funct3         = pkt_q.funct3;
  assign funct7         = pkt_q.funct7;
  assign op             = pkt_q.op;
  assign op_imm         = pkt_q.op_imm;
  assign out_pc         = pkt_q.pc;
  assign out_store_data = pkt_q.store_data;
  assign out_rd         = pkt_q.rd;
  assign out_is_load    = pkt_q.is_load;
  assign out_reg_write  = pkt_q.reg_write;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, load-use bubble, backpressure, flush, async reset.

module tb_id_ex_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc, in_imm;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic            in_uses_rs1, in_uses_rs2;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic            in_op, in_op_imm, in_is_load, in_reg_write;
  logic [XLEN-1:0] alu_res;
  logic            mem_fwd_valid;
  logic [4:0]      mem_fwd_rd;
  logic [XLEN-1:0] mem_fwd_data;
  logic            wb_fwd_valid;
  logic [4:0]      wb_fwd_rd;
  logic [XLEN-1:0] wb_fwd_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] a, b, out_pc, out_store_data;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            op, op_imm;
  logic [4:0]      out_rd;
  logic            out_is_load, out_reg_write;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.XLEN(XLEN), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_op(in_op), .in_op_imm(in_op_imm), .in_is_load(in_is_load), .in_reg_write(in_reg_write),
    .alu_res(alu_res),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .funct3(funct3), .funct7(funct7), .op(op), .op_imm(op_imm),
    .out_pc(out_pc), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_is_load(out_is_load), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step to 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic u1, input logic u2,
                     input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                     input logic [2:0] f3, input logic [6:0] f7,
                     input logic o, input logic oi, input logic ld, input logic [31:0] pc);
    in_valid = 1'b1;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_uses_rs1 = u1; in_uses_rs2 = u2;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm;
    in_funct3 = f3; in_funct7 = f7;
    in_op = o; in_op_imm = oi; in_is_load = ld; in_reg_write = 1'b1;
    in_pc = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_rs1_data = '0; in_rs2_data = '0;
    in_funct3 = '0; in_funct7 = '0; in_op = 1'b0; in_op_imm = 1'b0;
    in_is_load = 1'b0; in_reg_write = 1'b0; alu_res = '0;
    mem_fwd_valid = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;

    // Reset state
    step(); step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_funct7", {25'b0, funct7}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    step();

    // 1: ADD x3=x1+x2, then SUB x4=x3-x1 with x3 from the ALU
    ins(5'd1, 5'd2, 5'd3, 1, 1, 32'd20, 32'd7, 32'd0, 3'd0, 7'h00, 1, 0, 0, 32'h100);
    step();
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_a", a, 32'd20);
    chk("add_b", b, 32'd7);
    chk("add_pc", out_pc, 32'h100);
    ins(5'd3, 5'd1, 5'd4, 1, 1, 32'd0, 32'd20, 32'd0, 3'd0, 7'h20, 1, 0, 0, 32'h104);
    alu_res = 32'd27;
    step();
    chk("sub_a_fwd_alu", a, 32'd27);
    chk("sub_b", b, 32'd20);
    chk("sub_funct7", {25'b0, funct7}, 32'h20);
    chk("sub_rd", {27'b0, out_rd}, 32'd4);

    // 2: LW x5, then ADD x6=x5+x1 -> one bubble then MEM forward
    ins(5'd1, 5'd0, 5'd5, 1, 0, 32'h1000, 32'd0, 32'd4, 3'd2, 7'h00, 0, 1, 1, 32'h108);
    alu_res = 32'd0;
    step();
    chk("lw_is_load", {31'b0, out_is_load}, 32'd1);
    chk("lw_a", a, 32'h1000);
    chk("lw_b_imm", b, 32'd4);
    ins(5'd5, 5'd1, 5'd6, 1, 1, 32'hDEAD, 32'd20, 32'd0, 3'd0, 7'h00, 1, 0, 0, 32'h10C);
    #1;
    chk("lu_in_ready_stall", {31'b0, in_ready}, 32'd0);
    step();
    chk("lu_bubble", {31'b0, out_valid}, 32'd0);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'h55;
    #1;
    chk("lu_in_ready_free", {31'b0, in_ready}, 32'd1);
    step();
    chk("lu_add_valid", {31'b0, out_valid}, 32'd1);
    chk("lu_add_a_mem", a, 32'h55);
    chk("lu_add_b", b, 32'd20);
    chk("lu_add_rd", {27'b0, out_rd}, 32'd6);

    // 3: MEM beats WB for the same rd; WB used when MEM invalid
    ins(5'd7, 5'd0, 5'd8, 1, 1, 32'h33, 32'h44, 32'd0, 3'd0, 7'h00, 1, 0, 0, 32'h110);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'h11;
    wb_fwd_valid = 1'b1;  wb_fwd_rd = 5'd7;  wb_fwd_data = 32'h22;
    step();
    chk("prio_mem", a, 32'h11);
    chk("prio_rs2_x0", b, 32'd0);
    mem_fwd_valid = 1'b0;
    step();
    chk("prio_wb", a, 32'h22);
    wb_fwd_valid = 1'b0;

    // 4: x0 never forwards; ADDI imm and funct7 clearing; SRAI keeps funct7
    ins(5'd0, 5'd0, 5'd8, 1, 0, 32'h1234, 32'd0, 32'hFFFF_FF9C, 3'd0, 7'h20, 0, 1, 0, 32'h114);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hFFFF_FFFF;
    step();
    chk("x0_a", a, 32'd0);
    chk("addi_b", b, 32'hFFFF_FF9C);
    chk("addi_funct7", {25'b0, funct7}, 32'd0);
    mem_fwd_valid = 1'b0;
    ins(5'd1, 5'd0, 5'd10, 1, 0, 32'h80, 32'd0, 32'd3, 3'd5, 7'h20, 0, 1, 0, 32'h118);
    step();
    chk("srai_funct7", {25'b0, funct7}, 32'h20);
    chk("srai_a", a, 32'h80);
    chk("srai_funct3", {29'b0, funct3}, 32'd5);

    // 5: backpressure holds outputs, then flush kills held and blocks capture
    out_ready = 1'b0;
    ins(5'd2, 5'd3, 5'd9, 1, 1, 32'h900, 32'h901, 32'd0, 3'd0, 7'h00, 1, 0, 0, 32'h11C);
    #1;
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_a", a, 32'h80);
      chk("bp_rd", {27'b0, out_rd}, 32'd10);
      chk("bp_pc", out_pc, 32'h118);
    end
    flush = 1'b1;
    step();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("flush_no_capture_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_no_capture_rd", {27'b0, out_rd}, 32'd10);
    flush = 1'b0;
    step();
    chk("post_flush_valid", {31'b0, out_valid}, 32'd1);
    chk("post_flush_a", a, 32'h900);
    chk("post_flush_store", out_store_data, 32'h901);

    // 6: async reset pulse between edges
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_a", a, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    ins(5'd4, 5'd5, 5'd11, 1, 1, 32'h70, 32'h71, 32'd0, 3'd1, 7'h00, 1, 0, 0, 32'h120);
    step();
    chk("resume_valid", {31'b0, out_valid}, 32'd1);
    chk("resume_a", a, 32'h70);
    chk("resume_b", b, 32'h71);
    in_valid = 1'b0;
    step();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
